logic_unit_arbiter: RTL and testbench
=====================================

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, setting the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester n presents an operation.
REQ-005 The block SHALL have ports req0_ready and req1_ready, output, 1 bit each: the block accepts requester n this cycle.
REQ-006 The block SHALL have ports req0_op and req1_op, input, 2 bits each: opcode.
REQ-007 The block SHALL have ports req0_a, req0_b, req1_a and req1_b, input, WIDTH bits each: operands.
REQ-008 The block SHALL have port rsp_valid, output, 1 bit: a result is available.
REQ-009 The block SHALL have port rsp_ready, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have port rsp_id, output, 1 bit: index of the requester that owns the result.
REQ-011 The block SHALL have port rsp_data, output, WIDTH bits: the result.
REQ-012 The block SHALL have port busy, output, 1 bit: the FSM is not in IDLE.

Function
REQ-013 The block SHALL use the opcodes 00 AND, 01 OR, 10 XOR and 11 NOR, applied bitwise over WIDTH bits with no carry.
REQ-014 The block SHALL implement a three-state FSM: IDLE, EXEC and RESP.
REQ-015 In IDLE, the block SHALL assert reqN_ready combinationally for at most one requester, the granted one, and only while that requester's valid is high.
REQ-016 A transfer SHALL occur when valid and ready are both high; on a transfer the block SHALL register op, a, b and id, and move to EXEC.
REQ-017 In EXEC, the block SHALL compute the result, register it into rsp_data, and move to RESP after exactly one cycle.
REQ-018 In RESP, the block SHALL hold rsp_valid high with rsp_data and rsp_id stable until rsp_ready is high.
REQ-019 The RESP-to-IDLE transition SHALL occur on the cycle in which rsp_valid and rsp_ready are both high.
REQ-020 Latency SHALL be: transfer on cycle N, rsp_valid high on cycle N+2.
REQ-021 The minimum issue interval SHALL be 3 cycles.
REQ-022 Outside IDLE, both reqN_ready outputs SHALL be low, and requester inputs SHALL be ignored.
REQ-023 rsp_valid SHALL be high only in RESP.
REQ-024 If only one requester is valid, that requester SHALL be granted.
REQ-025 If both requesters are valid in the same IDLE cycle, the grant SHALL follow the policy defined in REQ-030 and REQ-031.
REQ-026 A requester that drops valid before its transfer SHALL lose nothing; no state changes without a transfer.
REQ-027 rsp_ready high outside RESP SHALL have no effect.

Reset
REQ-028 When rst_n is low, the block SHALL immediately force: state IDLE, rsp_valid 0, rsp_data 0, rsp_id 0, busy 0, both ready outputs 0, and round-robin pointer 0 (requester 0 favoured first).
REQ-029 Reset asserted mid-operation (in EXEC or RESP) SHALL discard the operation, and no response SHALL be produced for it.

Configuration
REQ-030 With macro LOGIC_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin: the pointer moves to the other requester after every transfer.
REQ-031 Without LOGIC_ARB_RR_EN, arbitration SHALL be fixed priority with requester 0 always winning, and no pointer register SHALL exist.

Structure
REQ-032 The opcode constants (OP_AND, OP_OR, OP_XOR, OP_NOR) and the FSM state encodings (S_IDLE, S_EXEC, S_RESP) SHALL reside in a shared header included by both the RTL and the bench.
REQ-033 The bitwise datapath SHALL be a separate combinational sub-module, logic_unit_32, taking op, a and b and producing y, instantiated once.

Verification
REQ-034 Single op test: req0 issues AND with a=0x80000001 and b=0xFFFFFFFF -> ready0 high in IDLE; two cycles later rsp_valid=1, rsp_id=0, rsp_data=0x80000001.
REQ-035 Opcode sweep test: a=0x00000003 and b=0x00000001 with each opcode -> AND=0x00000001, OR=0x00000003, XOR=0x00000002, NOR=0xFFFFFFFC.
REQ-036 Contention test: req0 and req1 held valid continuously -> with RR_EN, rsp_id alternates 0,1,0,1; without RR_EN, rsp_id is always 0 and req1 is never granted.
REQ-037 Backpressure test: rsp_ready held low for 5 cycles in RESP -> rsp_valid and rsp_data stable for those cycles, both ready outputs low, busy=1; the block returns to IDLE one cycle after rsp_ready rises.
REQ-038 Reset test: rst_n pulsed low during EXEC -> all outputs 0 immediately; no rsp_valid for the aborted op; the next request completes normally.
REQ-039 Idle test: no valid inputs for 10 cycles -> busy=0, rsp_valid=0, and rsp_ready toggling causes no change.

Source files
------------

// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the two-requester logic unit arbiter: opcode
// constants, FSM state encodings and the arbitration helper.
// Included by the RTL and by the bench through import.
package logic_unit_arbiter_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

  // Returns 1 when requester 1 should win. The favour1 argument only decides
  // genuine contention; a lone requester always wins.
  function automatic logic pick_req1(input logic v0, input logic v1, input logic favour1);
    logic win1;
    if (v0 && v1) begin
      win1 = favour1;
    end else begin
      win1 = v1;
    end
    return win1;
  endfunction

endpackage

// File: rtl/logic_unit_32.sv
// Purely combinational bitwise datapath: AND / OR / XOR / NOR over WIDTH bits.
import logic_unit_arbiter_pkg::*;

module logic_unit_32 #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] y_s;

  // Select the bitwise function named by the opcode.
  always_comb begin
    y_s = '0;
    case (op)
      OP_AND:  y_s = a & b;
      OP_OR:   y_s = a | b;
      OP_XOR:  y_s = a ^ b;
      OP_NOR:  y_s = ~(a | b);
      default: y_s = '0;
    endcase
  end

  assign y = y_s;

endmodule

// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter in front of a bitwise logic unit.
// IDLE grants one requester, EXEC computes the result for one cycle, RESP
// holds the result until the consumer takes it.
// Build option: define LOGIC_ARB_RR_EN for round-robin arbitration on
// contention; otherwise requester 0 has fixed priority and no pointer exists.
import logic_unit_arbiter_pkg::*;

module logic_unit_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  state_t           state_r;
  state_t           state_s;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             id_r;
  logic [WIDTH-1:0] rsp_data_r;
  logic [WIDTH-1:0] y_s;

  logic             idle_s;
  logic             favour1_s;
  logic             grant1_s;
  logic             ready0_s;
  logic             ready1_s;
  logic             xfer_s;
  logic [1:0]       sel_op_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;

`ifdef LOGIC_ARB_RR_EN
  logic ptr_r;

  // Round-robin pointer: after each transfer, favour the requester not just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 1'b0;
    end else if (xfer_s) begin
      ptr_r <= ~ready1_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign favour1_s = ptr_r;
`else
  assign favour1_s = 1'b0;
`endif

  // Grant and handshake: ready only in IDLE, only to the winner, only while it is valid.
  // Ready is also gated by rst_n so it drops the instant reset asserts.
  always_comb begin
    idle_s   = (state_r == S_IDLE);
    grant1_s = pick_req1(req0_valid, req1_valid, favour1_s);
    ready0_s = rst_n && idle_s && req0_valid && !grant1_s;
    ready1_s = rst_n && idle_s && req1_valid && grant1_s;
    xfer_s   = ready0_s || ready1_s;
  end

  // Operand mux feeding the capture registers.
  always_comb begin
    if (ready1_s) begin
      sel_op_s = req1_op;
      sel_a_s  = req1_a;
      sel_b_s  = req1_b;
    end else begin
      sel_op_s = req0_op;
      sel_a_s  = req0_a;
      sel_b_s  = req0_b;
    end
  end

  // Next-state logic for the IDLE -> EXEC -> RESP -> IDLE loop.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (xfer_s) begin
          state_s = S_EXEC;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_EXEC: begin
        state_s = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_RESP;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Capture the winning request on a transfer; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r <= 2'b00;
      a_r  <= '0;
      b_r  <= '0;
      id_r <= 1'b0;
    end else if (xfer_s) begin
      op_r <= sel_op_s;
      a_r  <= sel_a_s;
      b_r  <= sel_b_s;
      id_r <= ready1_s;
    end else begin
      op_r <= op_r;
      a_r  <= a_r;
      b_r  <= b_r;
      id_r <= id_r;
    end
  end

  logic_unit_32 #(
    .WIDTH(WIDTH)
  ) u_logic_unit (
    .op(op_r),
    .a (a_r),
    .b (b_r),
    .y (y_s)
  );

  // Result register, loaded only in EXEC so it stays stable through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_r <= '0;
    end else if (state_r == S_EXEC) begin
      rsp_data_r <= y_s;
    end else begin
      rsp_data_r <= rsp_data_r;
    end
  end

  assign req0_ready = ready0_s;
  assign req1_ready = ready1_s;
  assign rsp_valid  = (state_r == S_RESP);
  assign rsp_id     = id_r;
  assign rsp_data   = rsp_data_r;
  assign busy       = (state_r != S_IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter. The reference model tracks one
// outstanding transaction by its issue cycle: a response is due two cycles
// after the transfer and lasts until the consumer accepts it.
import logic_unit_arbiter_pkg::*;

module tb_logic_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op = 2'b00, req1_op = 2'b00;
  logic [31:0] req0_a = 32'h0, req0_b = 32'h0, req1_a = 32'h0, req1_b = 32'h0;
  logic        rsp_valid, rsp_id, busy;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;

  logic_unit_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef LOGIC_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Values to apply on the next step.
  logic        n_v0, n_v1, n_rr;
  logic [1:0]  n_op0, n_op1;
  logic [31:0] n_a0, n_b0, n_a1, n_b1;

  // Reference model state.
  bit          m_pend;
  int          m_issue;
  logic [31:0] m_data;
  bit          m_id;
  bit          m_ptr;
  int          cyc;
  bit          last_rv;
  int          id_seq[$];

  function automatic logic [31:0] ref_op(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check, then advance the model.
  task automatic step();
    bit idle, g1, e_r0, e_r1, e_rv;
    @(negedge clk);
    req0_valid = n_v0; req0_op = n_op0; req0_a = n_a0; req0_b = n_b0;
    req1_valid = n_v1; req1_op = n_op1; req1_a = n_a1; req1_b = n_b1;
    rsp_ready  = n_rr;
    #1;
    idle = !m_pend;
    e_rv = m_pend && (cyc >= m_issue + 2);
    if (n_v0 && n_v1) g1 = RR ? m_ptr : 1'b0;
    else              g1 = n_v1;
    e_r0 = idle && n_v0 && !g1;
    e_r1 = idle && n_v1 && g1;
    check("req0_ready", {31'h0, req0_ready}, {31'h0, e_r0});
    check("req1_ready", {31'h0, req1_ready}, {31'h0, e_r1});
    check("busy",       {31'h0, busy},       {31'h0, m_pend});
    check("rsp_valid",  {31'h0, rsp_valid},  {31'h0, e_rv});
    if (e_rv) begin
      check("rsp_data", rsp_data, m_data);
      check("rsp_id",   {31'h0, rsp_id}, {31'h0, m_id});
      if (n_rr) id_seq.push_back(int'(m_id));
    end
    last_rv = e_rv;
    if (e_rv && n_rr) m_pend = 1'b0;
    if (e_r0 || e_r1) begin
      m_pend  = 1'b1;
      m_issue = cyc;
      m_id    = e_r1;
      m_data  = e_r1 ? ref_op(n_op1, n_a1, n_b1) : ref_op(n_op0, n_a0, n_b0);
      m_ptr   = !e_r1;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic quiet();
    n_v0 = 1'b0; n_v1 = 1'b0; n_rr = 1'b1;
    n_op0 = OP_AND; n_op1 = OP_AND;
    n_a0 = 32'h0; n_b0 = 32'h0; n_a1 = 32'h0; n_b1 = 32'h0;
  endtask

  initial begin
    logic [31:0] sweep_exp [4];
    logic [31:0] held;
    bit seen;
    sweep_exp[0] = 32'h0000_0001; sweep_exp[1] = 32'h0000_0003;
    sweep_exp[2] = 32'h0000_0002; sweep_exp[3] = 32'hFFFF_FFFC;
    m_pend = 1'b0; m_issue = 0; m_data = 32'h0; m_id = 1'b0; m_ptr = 1'b0;
    cyc = 0; last_rv = 1'b0;
    quiet();

    // Reset state with requests pending: everything must read zero.
    req0_valid = 1'b1; req1_valid = 1'b1;
    #12;
    check("rst_ready0", {31'h0, req0_ready}, 32'h0);
    check("rst_ready1", {31'h0, req1_ready}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Single AND from requester 0, two cycles to response.
    n_v0 = 1'b1; n_op0 = OP_AND; n_a0 = 32'h8000_0001; n_b0 = 32'hFFFF_FFFF;
    step();
    quiet();
    step();
    step();
    check("single_data", rsp_data, 32'h8000_0001);
    check("single_valid", {31'h0, rsp_valid}, 32'h1);
    step();

    // Opcode sweep with fixed operands against hand-computed results.
    for (int i = 0; i < 4; i++) begin
      quiet();
      n_v0 = 1'b1; n_op0 = 2'(i); n_a0 = 32'h3; n_b0 = 32'h1;
      step();
      quiet();
      seen = 1'b0;
      for (int k = 0; k < 6 && !seen; k++) begin
        step();
        if (last_rv) begin
          seen = 1'b1;
          check("sweep_data", rsp_data, sweep_exp[i]);
        end
      end
      check("sweep_seen", {31'h0, seen}, 32'h1);
    end

    // Contention: both requesters valid continuously.
    quiet();
    id_seq.delete();
    n_v0 = 1'b1; n_v1 = 1'b1;
    n_op0 = OP_XOR; n_a0 = 32'h1234_5678; n_b0 = 32'hFFFF_0000;
    n_op1 = OP_OR;  n_a1 = 32'h0F0F_0000; n_b1 = 32'h0000_F0F0;
    for (int k = 0; k < 13; k++) step();
    check("contend_count", id_seq.size(), 32'd4);
    for (int k = 0; k < id_seq.size(); k++) begin
      check("contend_id", id_seq[k], RR ? 32'(k % 2) : 32'd0);
    end
    quiet(); n_rr = 1'b1;
    for (int k = 0; k < 3; k++) step();

    // Backpressure: consumer stalls in RESP, result must stay put.
    quiet();
    n_v1 = 1'b1; n_op1 = OP_NOR; n_a1 = 32'hA5A5_0000; n_b1 = 32'h0000_5A5A;
    step();
    n_v1 = 1'b0; n_rr = 1'b0; n_v0 = 1'b1;
    step();
    step();
    held = rsp_data;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_hold", rsp_data, held);
    end
    n_rr = 1'b1; n_v0 = 1'b0;
    step();
    step();
    quiet();

    // Reset asserted during EXEC discards the operation.
    n_v0 = 1'b1; n_op0 = OP_OR; n_a0 = 32'hDEAD_0000; n_b0 = 32'h0000_BEEF;
    step();
    @(negedge clk);
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_valid", {31'h0, rsp_valid}, 32'h0);
    check("mid_rst_data", rsp_data, 32'h0);
    check("mid_rst_id", {31'h0, rsp_id}, 32'h0);
    check("mid_rst_ready0", {31'h0, req0_ready}, 32'h0);
    check("mid_rst_ready1", {31'h0, req1_ready}, 32'h0);
    m_pend = 1'b0; m_ptr = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; rst_n = 1'b1;
    quiet();
    for (int k = 0; k < 3; k++) step();
    n_v0 = 1'b1; n_op0 = OP_XOR; n_a0 = 32'hFFFF_0000; n_b0 = 32'h0F0F_0F0F;
    step();
    quiet();
    for (int k = 0; k < 3; k++) step();

    // Idle: nothing valid, rsp_ready toggling must change nothing.
    for (int k = 0; k < 10; k++) begin
      n_rr = k[0];
      step();
      check("idle_data", rsp_data, 32'hF0F0_0F0F);
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 300; k++) begin
      n_v0 = ($urandom_range(0, 2) != 0);
      n_v1 = ($urandom_range(0, 2) != 0);
      n_op0 = 2'($urandom_range(0, 3)); n_op1 = 2'($urandom_range(0, 3));
      n_a0 = $urandom; n_b0 = $urandom; n_a1 = $urandom; n_b1 = $urandom;
      n_rr = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
